fft_twiddle_sequencer: RTL and testbench

Sequences twiddle factors for a radix-2 DIT FFT. The block reads the shared fixed-point sine table (one full period, SIZE_FFT entries) and streams one complex twiddle W_N^k per butterfly, stage by stage, over a valid/ready handshake to the butterfly datapath. The FFT controller starts it with a start pulse. A done pulse marks the end of the last stage.

---
 rtl/fft_twiddle_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_fft_twiddle_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_sequencer.sv
// fft_twiddle_sequencer
// Streams one complex twiddle W_N^k per radix-2 DIT butterfly, stage by
// stage, over a valid/ready handshake. Twiddles are looked up in a shared
// one-period sine table: cos comes from a quarter-period offset, and the
// imaginary part is -sin (forward) or +sin (inverse, conjugated twiddle).
// Values are passed through in the table's fixed-point format unchanged.

module fft_twiddle_sequencer #(
  parameter int BIT_WIDTH     = 32,
  parameter int DECIMAL_POINT = 16,
  parameter int SIZE_FFT      = 8,
  localparam int LOG_N        = $clog2(SIZE_FFT),
  localparam int STAGE_W      = $clog2(LOG_N) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BIT_WIDTH*SIZE_FFT-1:0] sine_wave_in,
  input  logic                          start,
  input  logic                          inverse,
  output logic                          busy,
  output logic                          done,
  output logic                          tw_val,
  input  logic                          tw_rdy,
  output logic [BIT_WIDTH-1:0]          tw_real,
  output logic [BIT_WIDTH-1:0]          tw_imag,
  output logic [LOG_N-1:0]              tw_k,
  output logic [STAGE_W-1:0]            tw_stage,
  output logic                          tw_last
);

  // Butterfly counter covers N/2 butterflies per stage, i.e. LOG_N-1 bits.
  localparam int BFLY_W = LOG_N - 1;

  // FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter end points: the last stage is LOG_N-1, the last butterfly
  // N/2-1 is all ones because N/2 is a power of two.
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG_N - 1);
  localparam logic [STAGE_W-1:0] STAGE_ONE  = STAGE_W'(1);
  localparam logic [BFLY_W-1:0]  BFLY_LAST  = '1;
  localparam logic [BFLY_W-1:0]  BFLY_ONE   = BFLY_W'(1);
  localparam logic [LOG_N-1:0]   QUARTER    = LOG_N'(SIZE_FFT / 4);

  // Reject unusable configurations at elaboration: the table must be a
  // power-of-two period of at least 4 entries and the binary point must
  // lie inside the word.
  generate
    if ((SIZE_FFT < 4) || ((1 << LOG_N) != SIZE_FFT)) begin : g_bad_size
      $error("fft_twiddle_sequencer: SIZE_FFT must be a power of two >= 4");
    end
    if ((DECIMAL_POINT < 0) || (DECIMAL_POINT >= BIT_WIDTH)) begin : g_bad_fmt
      $error("fft_twiddle_sequencer: DECIMAL_POINT outside BIT_WIDTH");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Sine table view
  // ---------------------------------------------------------------------
  logic [BIT_WIDTH-1:0] sine_tbl [SIZE_FFT];

  generate
    for (genvar gi = 0; gi < SIZE_FFT; gi++) begin : g_tbl
      assign sine_tbl[gi] = sine_wave_in[gi*BIT_WIDTH +: BIT_WIDTH];
    end
  endgenerate

  // Twiddle index for butterfly b of stage s: j = b mod 2^s, k = j << (L-1-s).
  function automatic logic [LOG_N-1:0] twiddle_index(
    input logic [STAGE_W-1:0] stage,
    input logic [BFLY_W-1:0]  bfly
  );
    logic [LOG_N-1:0] mask;
    logic [LOG_N-1:0] j;
    mask = (LOG_N'(1) << stage) - LOG_N'(1);
    j    = {1'b0, bfly} & mask;
    return j << ((LOG_N - 1) - int'(stage));
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]           state_q,    state_d;
  logic [STAGE_W-1:0]   s_q,        s_d;
  logic [BFLY_W-1:0]    b_q,        b_d;
  logic                 inv_q,      inv_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 tw_val_q,   tw_val_d;
  logic                 tw_last_q,  tw_last_d;
  logic [BIT_WIDTH-1:0] tw_real_q,  tw_real_d;
  logic [BIT_WIDTH-1:0] tw_imag_q,  tw_imag_d;
  logic [LOG_N-1:0]     tw_k_q,     tw_k_d;
  logic [STAGE_W-1:0]   tw_stage_q, tw_stage_d;

  logic                 accept;
  logic                 at_last;
  logic [LOG_N-1:0]     k_next;
  logic [LOG_N-1:0]     cos_idx;
  logic [BIT_WIDTH-1:0] sin_k;

  assign accept  = tw_val_q & tw_rdy;
  assign at_last = (s_q == STAGE_LAST) && (b_q == BFLY_LAST);

  // Sequencing FSM and (stage, butterfly) counters.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    inv_d   = inv_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          inv_d   = inverse;
          s_d     = '0;
          b_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (at_last) begin
            state_d = ST_DONE;
          end else if (b_q == BFLY_LAST) begin
            b_d = '0;
            s_d = s_q + STAGE_ONE;
          end else begin
            b_d = b_q + BFLY_ONE;
          end
        end
      end
      ST_DONE: begin
        // start seen here is deliberately dropped; it must come again in IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Table lookups for the twiddle selected by the next (stage, butterfly).
  always_comb begin
    k_next  = twiddle_index(s_d, b_d);
    cos_idx = k_next + QUARTER;
    sin_k   = sine_tbl[k_next];
  end

  // Registered output fields, derived from the counters they will describe.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    tw_val_d   = (state_d == ST_RUN);
    tw_last_d  = 1'b0;
    tw_real_d  = '0;
    tw_imag_d  = '0;
    tw_k_d     = '0;
    tw_stage_d = '0;
    if (tw_val_d) begin
      tw_last_d  = (s_d == STAGE_LAST) && (b_d == BFLY_LAST);
      tw_real_d  = sine_tbl[cos_idx];
      // Two's-complement negation wraps; the table never holds the most
      // negative code, so the wrap never changes a value.
      tw_imag_d  = inv_d ? sin_k : (BIT_WIDTH'(0) - sin_k);
      tw_k_d     = k_next;
      tw_stage_d = s_d;
    end
  end

  // State and output registers; asynchronous reset aborts any sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      b_q        <= '0;
      inv_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tw_val_q   <= 1'b0;
      tw_last_q  <= 1'b0;
      tw_real_q  <= '0;
      tw_imag_q  <= '0;
      tw_k_q     <= '0;
      tw_stage_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, regardless of statement order.
      state_q    <= state_d;
      s_q        <= s_d;
      b_q        <= b_d;
      inv_q      <= inv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tw_val_q   <= tw_val_d;
      tw_last_q  <= tw_last_d;
      tw_real_q  <= tw_real_d;
      tw_imag_q  <= tw_imag_d;
      tw_k_q     <= tw_k_d;
      tw_stage_q <= tw_stage_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tw_val   = tw_val_q;
  assign tw_last  = tw_last_q;
  assign tw_real  = tw_real_q;
  assign tw_imag  = tw_imag_q;
  assign tw_k     = tw_k_q;
  assign tw_stage = tw_stage_q;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Self-checking bench for fft_twiddle_sequencer: random backpressure and
// random start/inverse pokes, checked against a per-beat reference list
// built from the twiddle rules with plain arithmetic.

module tb_fft_twiddle_sequencer;

  localparam int BW    = 32;
  localparam int N     = 8;
  localparam int L     = 3;
  localparam int SW    = $clog2(L) + 1;
  localparam int HALF  = N / 2;
  localparam int TOTAL = HALF * L;

  logic            clk = 1'b0;
  logic            reset;
  logic [BW*N-1:0] sine_wave_in;
  logic            start;
  logic            inverse;
  logic            busy;
  logic            done;
  logic            tw_val;
  logic            tw_rdy;
  logic [BW-1:0]   tw_real;
  logic [BW-1:0]   tw_imag;
  logic [L-1:0]    tw_k;
  logic [SW-1:0]   tw_stage;
  logic            tw_last;

  fft_twiddle_sequencer #(
    .BIT_WIDTH    (BW),
    .DECIMAL_POINT(16),
    .SIZE_FFT     (N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sine_wave_in(sine_wave_in),
    .start       (start),
    .inverse     (inverse),
    .busy        (busy),
    .done        (done),
    .tw_val      (tw_val),
    .tw_rdy      (tw_rdy),
    .tw_real     (tw_real),
    .tw_imag     (tw_imag),
    .tw_k        (tw_k),
    .tw_stage    (tw_stage),
    .tw_last     (tw_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int s;
    int re;
    int im;
  } beat_t;

  int    total = 0;
  int    bad   = 0;
  int    tbl [N];
  beat_t exp_q [$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) sine_wave_in[i*BW +: BW] = tbl[i];
  endtask

  // Reference: every butterfly of every stage, in order.
  task automatic build_model(input bit inv);
    exp_q.delete();
    for (int s = 0; s < L; s++) begin
      for (int b = 0; b < HALF; b++) begin
        int j;
        int k;
        j = b % (2 ** s);
        k = j * (2 ** (L - 1 - s));
        exp_q.push_back('{k: k, s: s, re: tbl[(k + N/4) % N],
                          im: inv ? tbl[k] : -tbl[k]});
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":tw_val"},   int'(tw_val),   0);
    check({tag, ":busy"},     int'(busy),     0);
    check({tag, ":done"},     int'(done),     0);
    check({tag, ":tw_last"},  int'(tw_last),  0);
    check({tag, ":tw_real"},  int'(tw_real),  0);
    check({tag, ":tw_imag"},  int'(tw_imag),  0);
    check({tag, ":tw_k"},     int'(tw_k),     0);
    check({tag, ":tw_stage"}, int'(tw_stage), 0);
  endtask

  // One sequence: start, then sample each negedge. rdy_pct sets the
  // chance of tw_rdy per cycle; poke throws start/inverse noise at the
  // block during RUN and DONE; abort_at >= 0 fires reset at that beat.
  task automatic run_seq(input string name, input bit inv, input int rdy_pct,
                         input bit poke, input int abort_at);
    int beat    = 0;
    int dones   = 0;
    int cyc     = 0;
    int acc_cyc = -10;
    bit fin     = 1'b0;
    bit acc;
    build_model(inv);
    @(negedge clk);
    inverse = inv;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ":first_val"}, int'(tw_val), 1);
    check({name, ":busy_run"},  int'(busy),   1);
    while (!fin && cyc < 500) begin
      start = 1'b0;
      if (tw_val) begin
        if (abort_at >= 0 && beat == abort_at) begin
          #1 reset = 1'b1;
          #1;
          check({name, ":abort_val"},  int'(tw_val), 0);
          check({name, ":abort_busy"}, int'(busy),   0);
          @(posedge clk);
          @(negedge clk);
          check({name, ":abort_done"}, int'(done), 0);
          reset  = 1'b0;
          tw_rdy = 1'b0;
          return;
        end
        if (beat < TOTAL) begin
          beat_t e;
          e = exp_q[beat];
          check($sformatf("%s:k[%0d]", name, beat),     int'(tw_k),             e.k);
          check($sformatf("%s:stage[%0d]", name, beat), int'(tw_stage),         e.s);
          check($sformatf("%s:re[%0d]", name, beat),    int'($signed(tw_real)), e.re);
          check($sformatf("%s:im[%0d]", name, beat),    int'($signed(tw_imag)), e.im);
          check($sformatf("%s:last[%0d]", name, beat),  int'(tw_last),
                (beat == TOTAL - 1) ? 1 : 0);
        end else begin
          check({name, ":extra_beat"}, beat, TOTAL - 1);
        end
        if (poke) begin
          start   = ($urandom_range(0, 2) == 0);
          inverse = $urandom_range(0, 1);
        end
      end
      if (done) begin
        dones++;
        check({name, ":done_beats"}, beat, TOTAL);
        check({name, ":done_lat"},   cyc - acc_cyc, 1);
        check({name, ":done_val"},   int'(tw_val), 0);
        check({name, ":done_busy"},  int'(busy), 1);
        if (poke) start = 1'b1;
        fin = 1'b1;
      end
      tw_rdy = ($urandom_range(1, 100) <= rdy_pct);
      acc    = tw_val && tw_rdy;
      @(posedge clk);
      if (acc) begin
        beat++;
        acc_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    start  = 1'b0;
    tw_rdy = 1'b0;
    if (!fin) check({name, ":timeout"}, 0, 1);
    check({name, ":dones"},     dones,        1);
    check({name, ":post_done"}, int'(done),   0);
    check({name, ":post_busy"}, int'(busy),   0);
    check({name, ":post_val"},  int'(tw_val), 0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    inverse = 1'b0;
    tw_rdy  = 1'b0;
    tbl     = '{0, 46340, 65536, 46340, 0, -46340, -65536, -46340};
    load_table();
    #12 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_idle");

    run_seq("fwd",    1'b0, 100, 1'b0, -1);
    run_seq("inv",    1'b1, 100, 1'b0, -1);
    run_seq("bp",     1'b0,  45, 1'b0, -1);
    run_seq("poke",   1'b0,  70, 1'b1, -1);
    run_seq("abort",  1'b0, 100, 1'b0,  4);
    check_idle("after_abort");
    run_seq("replay", 1'b0, 100, 1'b0, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) tbl[i] = int'($urandom_range(0, 131072)) - 65536;
      load_table();
      run_seq($sformatf("rnd%0d", r), r[0], 30 + 20 * r, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
